// File: rtl/vliw_scoreboard_pkg.sv
// vliw_pkg: shared sizing, types and helpers for the VLIW register scoreboard.
//   NSLOT  issue slots per bundle
//   NREG   architectural registers (int and float unified)
//   MAXLAT maximum result latency in cycles
//   REGW/LATW/SLW derived widths of a register index, a latency count and a slot index
package vliw_pkg;
  localparam int NSLOT  = 4;
  localparam int NREG   = 64;
  localparam int MAXLAT = 4;
  localparam int REGW   = $clog2(NREG);
  localparam int LATW   = $clog2(MAXLAT + 1);
  localparam int SLW    = $clog2(NSLOT);

  typedef logic [SLW-1:0]  slot_t;
  typedef logic [REGW-1:0] reg_t;
  typedef logic [LATW-1:0] lat_t;

  typedef struct packed {
    logic  valid;
    slot_t slot;
  } fwd_sel_t;

  // Latency 0 behaves like 1; anything beyond MAXLAT is clamped.
  function automatic lat_t eff_lat(input lat_t l);
    if (l == lat_t'(0)) return lat_t'(1);
    if (l > lat_t'(MAXLAT)) return lat_t'(MAXLAT);
    return l;
  endfunction
endpackage

// File: rtl/vliw_scoreboard_if.sv
// vliw_scoreboard_if: decode <-> scoreboard bundle interface.
//   master (decode): drives stall, flush, issue_valid, rs1, rs2, rs_use, rd, rd_we, lat;
//                    receives dec_stall, fwd1_valid/slot, fwd2_valid/slot
//   slave (scoreboard): the mirror image
// Per-slot fields are packed, slot k at [k*W +: W]; rs_use bit 2k is rs1, 2k+1 is rs2.
interface vliw_scoreboard_if;
  import vliw_pkg::*;

  logic                    stall;
  logic                    flush;
  logic                    issue_valid;
  logic [NSLOT*REGW-1:0]   rs1;
  logic [NSLOT*REGW-1:0]   rs2;
  logic [2*NSLOT-1:0]      rs_use;
  logic [NSLOT*REGW-1:0]   rd;
  logic [NSLOT-1:0]        rd_we;
  logic [NSLOT*LATW-1:0]   lat;
  logic                    dec_stall;
  logic [NSLOT-1:0]        fwd1_valid;
  logic [NSLOT*SLW-1:0]    fwd1_slot;
  logic [NSLOT-1:0]        fwd2_valid;
  logic [NSLOT*SLW-1:0]    fwd2_slot;

  modport master (
    output stall, flush, issue_valid, rs1, rs2, rs_use, rd, rd_we, lat,
    input  dec_stall, fwd1_valid, fwd1_slot, fwd2_valid, fwd2_slot
  );

  modport slave (
    input  stall, flush, issue_valid, rs1, rs2, rs_use, rd, rd_we, lat,
    output dec_stall, fwd1_valid, fwd1_slot, fwd2_valid, fwd2_slot
  );
endinterface

// File: rtl/vliw_sb_check.sv
// vliw_sb_check: combinational hazard check for one source operand.
//   cnt    cycles until the source's value reaches its forwarding bus
//   prod   slot that produces it
//   src    source register index (r0 is never busy)
//   use_op operand is actually read
//   stall  value not available in time for execute
//   sel    forwarding select (valid + producing slot), zero when not forwarding
module vliw_sb_check
  import vliw_pkg::*;
(
  input  lat_t     cnt,
  input  slot_t    prod,
  input  reg_t     src,
  input  logic     use_op,
  output logic     stall,
  output fwd_sel_t sel
);

  always_comb begin
    stall = 1'b0;
    sel   = '0;
    if (use_op && src != reg_t'(0)) begin
      if (cnt > lat_t'(1)) begin
        stall = 1'b1;
      end else if (cnt == lat_t'(1)) begin
        sel.valid = 1'b1;
        sel.slot  = prod;
      end
    end
  end

endmodule

// File: rtl/vliw_scoreboard.sv
// vliw_scoreboard: per-register in-flight latency tracker for the decode stage.
//   clk, rst  clock and synchronous active-high reset
//   sb        slave side of vliw_scoreboard_if (bundle in, stall/forward selects out)
// cnt_q[r] counts cycles until r's result is on forwarding bus prod_q[r];
// 0 means the register file already holds it.
module vliw_scoreboard
  import vliw_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  vliw_scoreboard_if.slave   sb
);

  lat_t  cnt_q  [NREG];
  slot_t prod_q [NREG];
  lat_t  cnt_d  [NREG];
  slot_t prod_d [NREG];

  reg_t     rs1_k [NSLOT];
  reg_t     rs2_k [NSLOT];
  reg_t     rd_k  [NSLOT];
  lat_t     eff   [NSLOT];
  logic     [2*NSLOT-1:0] op_stall;
  fwd_sel_t op_sel [2*NSLOT];
  logic     [NSLOT-1:0] waw;
  logic     fire;

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    assign rs1_k[k] = sb.rs1[k*REGW +: REGW];
    assign rs2_k[k] = sb.rs2[k*REGW +: REGW];
    assign rd_k[k]  = sb.rd[k*REGW +: REGW];
    assign eff[k]   = eff_lat(sb.lat[k*LATW +: LATW]);

    vliw_sb_check u_chk1 (
      .cnt    (cnt_q[rs1_k[k]]),
      .prod   (prod_q[rs1_k[k]]),
      .src    (rs1_k[k]),
      .use_op (sb.rs_use[2*k]),
      .stall  (op_stall[2*k]),
      .sel    (op_sel[2*k])
    );

    vliw_sb_check u_chk2 (
      .cnt    (cnt_q[rs2_k[k]]),
      .prod   (prod_q[rs2_k[k]]),
      .src    (rs2_k[k]),
      .use_op (sb.rs_use[2*k+1]),
      .stall  (op_stall[2*k+1]),
      .sel    (op_sel[2*k+1])
    );

    // A new write must not land at or before an older in-flight one to the same rd.
    assign waw[k] = sb.rd_we[k] && (rd_k[k] != reg_t'(0)) &&
                    (cnt_q[rd_k[k]] != lat_t'(0)) && (cnt_q[rd_k[k]] >= eff[k]);
  end

  always_comb begin
    sb.dec_stall  = sb.issue_valid & ((|op_stall) | (|waw));
    sb.fwd1_valid = '0;
    sb.fwd1_slot  = '0;
    sb.fwd2_valid = '0;
    sb.fwd2_slot  = '0;
    if (sb.issue_valid) begin
      for (int k = 0; k < NSLOT; k++) begin
        sb.fwd1_valid[k]             = op_sel[2*k].valid;
        sb.fwd1_slot[k*SLW +: SLW]   = op_sel[2*k].slot;
        sb.fwd2_valid[k]             = op_sel[2*k+1].valid;
        sb.fwd2_slot[k*SLW +: SLW]   = op_sel[2*k+1].slot;
      end
    end
  end

  assign fire = sb.issue_valid & ~sb.dec_stall & ~sb.stall & ~sb.flush & ~rst;

  // Everything drains by one; issuing slots then overwrite, ascending so the
  // highest slot writing a shared rd wins.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r]  = (cnt_q[r] != lat_t'(0)) ? cnt_q[r] - lat_t'(1) : lat_t'(0);
      prod_d[r] = prod_q[r];
    end
    if (fire) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (sb.rd_we[k] && rd_k[k] != reg_t'(0)) begin
          cnt_d[rd_k[k]]  = eff[k];
          prod_d[rd_k[k]] = slot_t'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r]  <= '0;
        prod_q[r] <= '0;
      end
    end else if (!sb.stall) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r]  <= cnt_d[r];
        prod_q[r] <= prod_d[r];
      end
    end
  end

endmodule
